// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag indices for the ALU command issuer (ALU_ISSUER_ACCUM_EN adds use_acc to the command payload)
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Bit positions inside alu_flag / rsp_flag
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_ZERO = 1;

    // The use_acc bit only travels through the FIFO when the accumulator exists
`ifdef ALU_ISSUER_ACCUM_EN
    localparam int CMD_ACC_BITS = 1;
`else
    localparam int CMD_ACC_BITS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with wrap-bit pointers, payload {use_acc, op, b, a} (use_acc only with ALU_ISSUER_ACCUM_EN)
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    localparam int PW   = 2 * W + 3 + CMD_ACC_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    output logic          ready_o,
    input  logic [PW-1:0] data_i,
    input  logic          pop_i,
    output logic [PW-1:0] data_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // Same index with opposite wrap bits means the writer lapped the reader
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign ready_o = !full;
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the index field wraps modulo DEPTH, the top bit toggles per lap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them to an external ALU and holds each response (ALU_ISSUER_ACCUM_EN enables the accumulator)
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_use_acc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic [2:0]   alu_flag,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [2:0]   rsp_flag
);

    localparam int PW = 2 * W + 3 + CMD_ACC_BITS;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_data, rd_data;
    logic          fifo_empty;
    logic          pop;
    logic [W-1:0]  head_a, head_b;
    logic [2:0]    head_op;
    logic [W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [W-1:0]  rsp_result_q, rsp_result_d;
    logic [2:0]    rsp_flag_q, rsp_flag_d;
    logic [1:0]    unused_flag;

    // Only the overflow bit of the ALU flags is meaningful here
    assign unused_flag = alu_flag[1:0];

`ifdef ALU_ISSUER_ACCUM_EN
    logic         head_use_acc;
    logic [W-1:0] acc_q, acc_d;

    assign wr_data = {cmd_use_acc, cmd_op, cmd_b, cmd_a};
    assign {head_use_acc, head_op, head_b, head_a} = rd_data;
`else
    logic unused_use_acc;

    assign unused_use_acc = cmd_use_acc;
    assign wr_data = {cmd_op, cmd_b, cmd_a};
    assign {head_op, head_b, head_a} = rd_data;
`endif

    alu_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .ready_o (cmd_ready),
        .data_i  (wr_data),
        .pop_i   (pop),
        .data_o  (rd_data),
        .empty_o (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: one cycle each for pop, capture and (at least) respond
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = RESPOND;
            RESPOND: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop and load ALU operands in IDLE, capture the result in ISSUE
    always_comb begin
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
`ifdef ALU_ISSUER_ACCUM_EN
        acc_d        = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    alu_a_d  = head_a;
                    alu_b_d  = head_b;
                    alu_op_d = head_op;
`ifdef ALU_ISSUER_ACCUM_EN
                    // acc_q already holds the previous result by the time we are back in IDLE
                    if (head_use_acc) alu_a_d = acc_q;
`endif
                end
            end
            ISSUE: begin
                rsp_result_d            = alu_result;
                rsp_flag_d              = '0;
                rsp_flag_d[FLAG_OVF]    = alu_flag[FLAG_OVF];
                rsp_flag_d[FLAG_ZERO]   = (alu_result == '0);
`ifdef ALU_ISSUER_ACCUM_EN
                acc_d                   = alu_result;
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers; everything clears asynchronously so in-flight work is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
        end
    end

`ifdef ALU_ISSUER_ACCUM_EN
    // Accumulator tracks the most recent captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == RESPOND);
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer with an external reference ALU
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [2:0]   cmd_op = 3'b000;
    logic         cmd_use_acc = 1'b0;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic [2:0]   alu_flag;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flag    (rsp_flag)
    );

    // External ALU: overflow flag is signed overflow of ADD only
    always_comb begin
        alu_result = '0;
        alu_flag   = 3'b000;
        case (alu_op)
            OP_ADD: begin
                alu_result  = alu_a + alu_b;
                alu_flag[2] = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            OP_SUB: alu_result = alu_a - alu_b;
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_NOT: alu_result = ~alu_a;
            OP_SHL: alu_result = alu_a << 1;
            OP_SHR: alu_result = alu_a >> 1;
            default: alu_result = '0;
        endcase
    end

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic ua, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Called just after a negedge; waits for a response, captures it and completes the handshake
    task automatic pop_rsp(output logic [W-1:0] r, output logic [2:0] f, output bit ok);
        ok = 1'b0; r = '0; f = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1; r = rsp_result; f = rsp_flag; rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (alu_a !== 4'h0) begin errors++; $display("FAIL reset_alu_a got %h want 0", alu_a); end
        checks++; if (alu_b !== 4'h0) begin errors++; $display("FAIL reset_alu_b got %h want 0", alu_b); end
        checks++; if (alu_op !== 3'b000) begin errors++; $display("FAIL reset_alu_op got %b want 000", alu_op); end
        checks++; if (rsp_result !== 4'h0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
        checks++; if (rsp_flag !== 3'b000) begin errors++; $display("FAIL reset_rsp_flag got %b want 000", rsp_flag); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_add_latency();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 4'h3; cmd_b = 4'h4; cmd_op = OP_ADD; cmd_use_acc = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_t0_valid got %b want 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_t1_valid got %b want 0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op} !== {4'h3, 4'h4, OP_ADD})
            begin errors++; $display("FAIL lat_issue_operands got %h %h %b want 3 4 000", alu_a, alu_b, alu_op); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_t2_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_result !== 4'h7) begin errors++; $display("FAIL add_3_4_result got %h want 7", rsp_result); end
        checks++; if (rsp_flag !== 3'b000) begin errors++; $display("FAIL add_3_4_flag got %b want 000", rsp_flag); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_after_hs_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_add_overflow();
        bit ok, rok;
        logic [W-1:0] r;
        logic [2:0] f;
        push_cmd(4'h8, 4'h8, OP_ADD, 1'b0, ok);
        pop_rsp(r, f, rok);
        checks++; if ({ok, rok} !== 2'b11) begin errors++; $display("FAIL ovf_handshake got %b want 11", {ok, rok}); end
        checks++; if (r !== 4'h0) begin errors++; $display("FAIL add_8_8_result got %h want 0", r); end
        checks++; if (f !== 3'b110) begin errors++; $display("FAIL add_8_8_flag got %b want 110", f); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av [5] = '{4'hA, 4'hC, 4'h5, 4'h2, 4'h9};
        logic [W-1:0] bv [5] = '{4'h6, 4'h3, 4'h2, 4'h5, 4'h0};
        logic [2:0]   ov [5] = '{OP_XOR, OP_AND, OP_OR, OP_SUB, OP_SHL};
        logic [W-1:0] er [5] = '{4'hC, 4'h0, 4'h7, 4'hD, 4'h2};
        logic [2:0]   ef [5] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        bit ok;
        logic [W-1:0] r;
        logic [2:0] f;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_a = av[i]; cmd_b = bv[i]; cmd_op = ov[i]; cmd_use_acc = 1'b0;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before_%0d got %b want 1", i, cmd_ready); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", cmd_ready); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_result, rsp_flag, cmd_ready} !== {1'b1, 4'hC, 3'b000, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%b r=%h f=%b rdy=%b want v=1 r=c f=000 rdy=0",
                         i, rsp_valid, rsp_result, rsp_flag, cmd_ready);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            pop_rsp(r, f, ok);
            checks++;
            if ({ok, r, f} !== {1'b1, er[i], ef[i]}) begin
                errors++;
                $display("FAIL b2b_rsp_%0d got ok=%b r=%h f=%b want ok=1 r=%h f=%b", i, ok, r, f, er[i], ef[i]);
            end
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit seen;
        logic [W-1:0] r;
        logic [2:0] f;
        rsp_ready = 1'b0;
        push_cmd(4'h1, 4'h1, OP_ADD, 1'b0, ok);
        push_cmd(4'h5, 4'h6, OP_OR, 1'b0, ok);
        push_cmd(4'h3, 4'h3, OP_AND, 1'b0, ok);
        push_cmd(4'h7, 4'h1, OP_XOR, 1'b0, ok);
        pop_rsp(r, f, ok);
        checks++; if ({ok, r} !== {1'b1, 4'h2}) begin errors++; $display("FAIL midop_first_rsp got ok=%b r=%h want ok=1 r=2", ok, r); end
        @(negedge clk);
        checks++; if ({rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 4'h5, 4'h6, OP_OR})
            begin errors++; $display("FAIL midop_issue got v=%b %h %h %b want 0 5 6 011", rsp_valid, alu_a, alu_b, alu_op); end
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midop_rst_ready got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_rst_valid got %b want 0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op} !== 11'h0) begin errors++; $display("FAIL midop_rst_alu got %h %h %b want 0 0 000", alu_a, alu_b, alu_op); end
        checks++; if ({rsp_result, rsp_flag} !== 7'h0) begin errors++; $display("FAIL midop_rst_rsp got %h %b want 0 000", rsp_result, rsp_flag); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_rsp_after_rst got %b want 0", seen); end
    endtask

    task automatic test_accum();
        bit ok1, ok2, rok1, rok2;
        logic [W-1:0] r1, r2;
        logic [2:0] f1, f2;
        logic [W-1:0] exp2;
`ifdef ALU_ISSUER_ACCUM_EN
        exp2 = 4'h7;
`else
        exp2 = 4'h3;
`endif
        rsp_ready = 1'b0;
        push_cmd(4'h1, 4'h2, OP_ADD, 1'b0, ok1);
        push_cmd(4'hF, 4'h4, OP_ADD, 1'b1, ok2);
        pop_rsp(r1, f1, rok1);
        pop_rsp(r2, f2, rok2);
        checks++; if ({ok1, ok2, rok1, rok2} !== 4'b1111) begin errors++; $display("FAIL acc_handshakes got %b want 1111", {ok1, ok2, rok1, rok2}); end
        checks++; if ({r1, f1} !== {4'h3, 3'b000}) begin errors++; $display("FAIL acc_first got r=%h f=%b want r=3 f=000", r1, f1); end
        checks++; if ({r2, f2} !== {exp2, 3'b000}) begin errors++; $display("FAIL acc_second got r=%h f=%b want r=%h f=000", r2, f2, exp2); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_add_overflow();
        test_back_to_back();
        test_reset_midop();
        test_accum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
